// File: rtl/knn_pkg.sv
// knn_pkg: FSM state encoding and width helper shared by the KNN blocks
package knn_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, SELECT, DONE} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/knn_class_counter.sv
// knn_class_counter: per-class vote counters with a serial argmax scan
module knn_class_counter
  import knn_pkg::*;
#(
  parameter int TYPE_W = 3,
  parameter int K = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  input  logic [TYPE_W-1:0]       inc_type,
  input  logic                    sel,
  input  logic [TYPE_W-1:0]       sel_class,
  output logic [TYPE_W-1:0]       res_class,
  output logic [clog2(K+1)-1:0]   res_votes
);
  localparam int CW = clog2(K + 1);
  logic [CW-1:0] cnt [1 << TYPE_W];
  logic [CW-1:0] best_votes;
  logic [TYPE_W-1:0] best_class;
  logic upd;
  // res_* already include the class being scanned, so the caller can latch the winner on the last scan cycle
  assign upd = sel && (cnt[sel_class] > best_votes);
  assign res_class = upd ? sel_class : best_class;
  assign res_votes = upd ? cnt[sel_class] : best_votes;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < (1 << TYPE_W); c++) cnt[c] <= '0;
      best_class <= '0;
      best_votes <= '0;
    end else begin
      if (inc) cnt[inc_type] <= cnt[inc_type] + CW'(1);
      if (upd) begin
        best_class <= sel_class;
        best_votes <= cnt[sel_class];
      end
    end
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest entries of a sorted distance array
module knn_vote
  import knn_pkg::*;
#(
  parameter int L = 5,
  parameter int W = 16,
  parameter int TYPE_W = 3,
  parameter int K = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [W*(1<<L)-1:0]         in,
  input  logic [TYPE_W*(1<<L)-1:0]    in_type,
  output logic                        in_ready,
  output logic [TYPE_W-1:0]           out_class,
  output logic [clog2(K+1)-1:0]       out_votes,
  output logic [W-1:0]                out_kdist,
  output logic                        out_valid,
  output logic                        drop
);
  localparam int CW = clog2(K + 1);
  if (K < 1 || K > (1 << L)) begin : g_bad_k
    $error("knn_vote: K must satisfy 1 <= K <= 2**L");
  end
  state_t state;
  logic [W-1:0] dist_q [K];
  logic [TYPE_W-1:0] type_q [K];
  logic [CW-1:0] idx;
  logic [TYPE_W-1:0] cls;
  logic [TYPE_W-1:0] res_class;
  logic [CW-1:0] res_votes;
  logic unused_far;
  // entries K..N-1 are intentionally ignored
  assign unused_far = ^{in, in_type};
  assign in_ready = state == IDLE;
  knn_class_counter #(.TYPE_W(TYPE_W), .K(K)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && in_valid),
    .inc(state == COUNT),
    .inc_type(type_q[idx]),
    .sel(state == SELECT),
    .sel_class(cls),
    .res_class(res_class),
    .res_votes(res_votes)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      drop <= 1'b0;
      out_class <= '0;
      out_votes <= '0;
      out_kdist <= '0;
      idx <= '0;
      cls <= '0;
    end else begin
      drop <= in_valid && state != IDLE;
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < K; i++) begin
            dist_q[i] <= in[W*i +: W];
            type_q[i] <= in_type[TYPE_W*i +: TYPE_W];
          end
          idx <= '0;
          state <= COUNT;
        end
        COUNT: begin
          idx <= idx + CW'(1);
          cls <= '0;
          if (idx == CW'(K - 1)) state <= SELECT;
        end
        SELECT: begin
          cls <= cls + TYPE_W'(1);
          if (&cls) begin
            out_class <= res_class;
            out_votes <= res_votes;
            out_kdist <= dist_q[K-1];
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed vectors with a scoreboard-driven result monitor
module tb_knn_vote;
  localparam int L = 5, W = 16, TW = 3, K = 5, N = 32, C = 8, VW = 3;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [W*N-1:0] in_bus = '0;
  logic [TW*N-1:0] typ_bus = '0;
  logic in_ready, out_valid, drop;
  logic [TW-1:0] out_class;
  logic [VW-1:0] out_votes;
  logic [W-1:0] out_kdist;
  always #5 clk = ~clk;
  knn_vote #(.L(L), .W(W), .TYPE_W(TW), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bus), .in_type(typ_bus),
    .in_ready(in_ready), .out_class(out_class), .out_votes(out_votes),
    .out_kdist(out_kdist), .out_valid(out_valid), .drop(drop)
  );
  typedef struct {int cls; int votes; int kdist; int acc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, cyc = 0, n_results = 0, n_drops = 0;
  int last_out = 0, prev_out = 0, exp_n = 0, d0 = 0;
  logic prev_ov = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (prev_ov && !rst) chk("valid_one_cycle", out_valid, 0);
    prev_ov = out_valid;
    if (drop) n_drops++;
    if (!rst && out_valid) begin
      n_results++;
      prev_out = last_out;
      last_out = cyc;
      chk("result_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_class", out_class, mon_e.cls);
        chk("out_votes", out_votes, mon_e.votes);
        chk("out_kdist", out_kdist, mon_e.kdist);
        chk("latency", cyc - mon_e.acc + 1, K + C + 1);
      end
    end
  end
  task automatic load(input int d[K], input int t[K], input int fd, input int ft);
    for (int i = 0; i < N; i++) begin
      if (i < K) begin
        in_bus[W*i +: W] = W'(d[i]);
        typ_bus[TW*i +: TW] = TW'(t[i]);
      end else begin
        in_bus[W*i +: W] = W'(fd);
        typ_bus[TW*i +: TW] = TW'(ft);
      end
    end
  endtask
  task automatic send(input int d[K], input int t[K], input int fd, input int ft,
                      input bit expect_res, input int ec, input int ev);
    int w = 0;
    exp_t e;
    load(d, t, fd, ft);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("in_ready_timeout", in_ready, 1);
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    if (expect_res) begin
      e.cls = ec; e.votes = ev; e.kdist = d[K-1]; e.acc = cyc;
      sb.push_back(e);
      exp_n++;
    end
  endtask
  task automatic wait_results(input int target);
    int w = 0;
    while (n_results < target && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (n_results < target) chk("result_timeout", n_results, target);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drop", drop, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_votes", out_votes, 0);
    chk("rst_out_kdist", out_kdist, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    @(negedge clk);
    send('{1, 3, 4, 9, 12}, '{2, 2, 5, 2, 5}, 16'hFFFF, 7, 1, 2, 3);
    wait_results(exp_n);
    send('{2, 5, 7, 8, 20}, '{4, 1, 4, 1, 7}, 100, 4, 1, 1, 2);
    wait_results(exp_n);
    send('{10, 20, 30, 40, 50}, '{0, 0, 0, 0, 0}, 0, 6, 1, 0, 5);
    wait_results(exp_n);
    send('{0, 1, 2, 3, 65535}, '{7, 7, 0, 7, 1}, 0, 0, 1, 7, 3);
    wait_results(exp_n);
    d0 = n_drops;
    send('{5, 6, 7, 8, 9}, '{3, 3, 3, 3, 3}, 0, 0, 1, 3, 5);
    repeat (3) @(negedge clk);
    typ_bus = '0;
    in_valid = 1;
    @(negedge clk);
    chk("drop_pulse", drop, 1);
    in_valid = 0;
    @(negedge clk);
    chk("drop_cleared", drop, 0);
    wait_results(exp_n);
    repeat (3) @(negedge clk);
    chk("hold_class", out_class, 3);
    chk("hold_votes", out_votes, 5);
    chk("hold_kdist", out_kdist, 9);
    chk("drop_count", n_drops - d0, 1);
    send('{1, 1, 1, 1, 1}, '{5, 5, 5, 5, 5}, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_class", out_class, 0);
    chk("abort_out_votes", out_votes, 0);
    chk("abort_out_kdist", out_kdist, 0);
    chk("abort_in_ready", in_ready, 1);
    rst = 0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    send('{2, 4, 6, 8, 10}, '{6, 5, 6, 5, 6}, 0, 5, 1, 6, 3);
    wait_results(exp_n);
    @(negedge clk);
    load('{9, 9, 9, 9, 9}, '{4, 4, 4, 4, 4}, 0, 4);
    rst = 1;
    in_valid = 1;
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    chk("rst_wins_drop", drop, 0);
    chk("rst_wins_in_ready", in_ready, 1);
    @(negedge clk);
    chk("rst_wins_idle", in_ready, 1);
    d0 = n_drops;
    send('{3, 3, 3, 3, 3}, '{1, 1, 2, 2, 1}, 0, 2, 1, 1, 3);
    send('{1, 2, 3, 4, 5}, '{0, 3, 3, 0, 0}, 0, 3, 1, 0, 3);
    wait_results(exp_n);
    chk("b2b_gap", last_out - prev_out, K + C + 2);
    chk("b2b_no_drop", n_drops - d0, 0);
    repeat (30) @(negedge clk);
    chk("result_count", n_results, exp_n);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
